alu_seq: RTL and testbench

Parametrised, sequential successor to the CPU datapath ALU. It adds true carry-out, overflow, half-carry and zero flags, rotate-capable shifts, and a BCD add/subtract mode executed nibble-serially by an internal state machine. It sits between the CPU input latches and the internal buses. Operations are started with a start/busy/done handshake, and the result is held in a registered adder hold register (o_add).

---
 rtl/alu_seq.sv | 207 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: 1-edge binary ops and nibble-serial BCD add/subtract.
// The BCD engine is built only when CPU6502_ALU_DECIMAL_EN is defined.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_b_inv,
    input  logic             i_carry,
    output logic [WIDTH-1:0] o_add,
    output logic             o_acr,
    output logic             o_avr,
    output logic             o_hc,
    output logic             o_zr,
    output logic             o_busy,
    output logic             o_done
);

    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_EOR = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_SRS = 3'd4;
    localparam logic [2:0] OP_SLS = 3'd5;

    logic [WIDTH-1:0] add_q;
    logic             acr_q;
    logic             avr_q;
    logic             hc_q;
    logic             done_q;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] bin_res;
    logic [WIDTH:0]   sum_full;
    logic [4:0]       sum_low;
    logic             bin_acr;
    logic             bin_avr;
    logic             bin_hc;
    logic             bin_take;

    // Ops 6/7 only reach this path when the decimal engine is absent.
    always_comb begin
        case (i_op)
            3'd6:    b_eff = i_b;
            3'd7:    b_eff = ~i_b;
            default: b_eff = i_b_inv ? ~i_b : i_b;
        endcase
        sum_full = {1'b0, i_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, i_carry};
        sum_low  = {1'b0, i_a[3:0]} + {1'b0, b_eff[3:0]} + {4'b0000, i_carry};
        bin_res  = sum_full[WIDTH-1:0];
        bin_acr  = 1'b0;
        bin_avr  = 1'b0;
        bin_hc   = 1'b0;
        case (i_op)
            OP_AND: bin_res = i_a & b_eff;
            OP_EOR: bin_res = i_a ^ b_eff;
            OP_OR:  bin_res = i_a | b_eff;
            OP_SRS: begin
                bin_res = {i_carry, i_a[WIDTH-1:1]};
                bin_acr = i_a[0];
            end
            OP_SLS: begin
                bin_res = {i_a[WIDTH-2:0], i_carry};
                bin_acr = i_a[WIDTH-1];
            end
            default: begin
                bin_acr = sum_full[WIDTH];
                bin_avr = (i_a[WIDTH-1] == b_eff[WIDTH-1]) &&
                          (sum_full[WIDTH-1] != i_a[WIDTH-1]);
                bin_hc  = sum_low[4];
            end
        endcase
    end

`ifdef CPU6502_ALU_DECIMAL_EN
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {S_IDLE, S_DEC} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q;
    logic             sub_q;
    logic             hc_dec_q;

    logic [4:0]       dig_sum;
    logic [4:0]       dig_diff;
    logic [3:0]       digit;
    logic             c_new;
    logic             dec_take;
    logic             dec_last;
    logic [WIDTH-1:0] dec_res;

    assign dec_take = i_start && (state_q == S_IDLE) && (i_op[2:1] == 2'b11);
    assign bin_take = i_start && (state_q == S_IDLE) && (i_op[2:1] != 2'b11);
    assign dec_last = (state_q == S_DEC) && (cnt_q == CW'(NIB - 1));
    assign o_busy   = (state_q == S_DEC);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (dec_take) state_d = S_DEC;
            S_DEC:   if (dec_last) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One BCD digit per edge; subtract carries "not borrow".
    always_comb begin
        dig_sum  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, c_q};
        dig_diff = {1'b0, a_q[3:0]} - {1'b0, b_q[3:0]} - {4'b0000, ~c_q};
        digit    = dig_sum[3:0];
        c_new    = 1'b0;
        if (sub_q) begin
            if (dig_diff[4]) begin
                digit = dig_diff[3:0] + 4'd10;
                c_new = 1'b0;
            end else begin
                digit = dig_diff[3:0];
                c_new = 1'b1;
            end
        end else if (dig_sum > 5'd9) begin
            digit = dig_sum[3:0] + 4'd6;
            c_new = 1'b1;
        end
        dec_res = (res_q >> 4) | (WIDTH'(digit) << (WIDTH - 4));
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            sub_q    <= 1'b0;
            hc_dec_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (dec_take) begin
                a_q   <= i_a;
                b_q   <= i_b;
                c_q   <= i_carry;
                sub_q <= i_op[0];
                cnt_q <= '0;
                res_q <= '0;
            end else if (state_q == S_DEC) begin
                a_q   <= a_q >> 4;
                b_q   <= b_q >> 4;
                c_q   <= c_new;
                res_q <= dec_res;
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == '0) hc_dec_q <= c_new;
            end
        end
    end
`else
    assign bin_take = i_start;
    assign o_busy   = 1'b0;
`endif

    // Result and flags change only on a completing edge.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            add_q  <= '0;
            acr_q  <= 1'b0;
            avr_q  <= 1'b0;
            hc_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bin_take) begin
                add_q  <= bin_res;
                acr_q  <= bin_acr;
                avr_q  <= bin_avr;
                hc_q   <= bin_hc;
                done_q <= 1'b1;
            end
`ifdef CPU6502_ALU_DECIMAL_EN
            else if (dec_last) begin
                add_q  <= dec_res;
                acr_q  <= c_new;
                avr_q  <= 1'b0;
                hc_q   <= (cnt_q == '0) ? c_new : hc_dec_q;
                done_q <= 1'b1;
            end
`endif
        end
    end

    assign o_add  = add_q;
    assign o_acr  = acr_q;
    assign o_avr  = avr_q;
    assign o_hc   = hc_q;
    assign o_zr   = (add_q == '0);
    assign o_done = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8); decimal expectations follow CPU6502_ALU_DECIMAL_EN.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         b_inv;
    logic         carry;
    logic [W-1:0] o_add;
    logic         o_acr, o_avr, o_hc, o_zr, o_busy, o_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string        name;
        logic [W-1:0] add;
        logic         acr;
        logic         avr;
        logic         hc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_op(op),
        .i_a(a), .i_b(b), .i_b_inv(b_inv), .i_carry(carry),
        .o_add(o_add), .o_acr(o_acr), .o_avr(o_avr), .o_hc(o_hc),
        .o_zr(o_zr), .o_busy(o_busy), .o_done(o_done)
    );

    // Every completion pops one expectation; a completion with nothing pending is an error.
    always @(negedge clk) begin
        exp_t e;
        if (o_done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got o_add=%h required no completion", o_add);
            end else begin
                e = sb.pop_front();
                if ({o_add, o_acr, o_avr, o_hc, o_zr} !== {e.add, e.acr, e.avr, e.hc, (e.add == '0)}) begin
                    errors++;
                    $display("FAIL %s got add=%h acr=%b avr=%b hc=%b zr=%b required add=%h acr=%b avr=%b hc=%b zr=%b",
                             e.name, o_add, o_acr, o_avr, o_hc, o_zr, e.add, e.acr, e.avr, e.hc, (e.add == '0));
                end else begin
                    $display("ok %s add=%h acr=%b avr=%b hc=%b zr=%b", e.name, o_add, o_acr, o_avr, o_hc, o_zr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish required finish before timeout");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic inv, input logic c);
        op = o; a = av; b = bv; b_inv = inv; carry = c; start = 1'b1;
    endtask

    task automatic push(input string n, input logic [W-1:0] ad, input logic ac,
                        input logic av, input logic h);
        exp_t e;
        e.name = n; e.add = ad; e.acr = ac; e.avr = av; e.hc = h;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input string n);
        for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending required 0 pending", n, sb.size());
            sb.delete();
        end
    endtask

    task automatic run_op(input string n, input logic [2:0] o, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic inv, input logic c,
                          input logic [W-1:0] ad, input logic ac, input logic avr, input logic h);
        @(negedge clk);
        issue(o, av, bv, inv, c);
        push(n, ad, ac, avr, h);
        @(negedge clk);
        start = 1'b0;
        wait_drain(n);
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input logic inv, input logic c);
        exp_t e;
        logic [W-1:0] bb;
        int           ua, sa;
        bb = inv ? ~bv : bv;
        e.name = "random"; e.acr = 1'b0; e.avr = 1'b0; e.hc = 1'b0;
        case (o)
            3'd0: begin
                ua = int'(av) + int'(bb) + int'(c);
                sa = int'($signed(av)) + int'($signed(bb)) + int'(c);
                e.add = ua[W-1:0];
                e.acr = (ua > 255);
                e.avr = (sa > 127) || (sa < -128);
                e.hc  = ((int'(av) % 16) + (int'(bb) % 16) + int'(c)) > 15;
            end
            3'd1: e.add = av & bb;
            3'd2: e.add = av ^ bb;
            3'd3: e.add = av | bb;
            3'd4: begin e.add = (av / 2) + (c ? 8'h80 : 8'h00); e.acr = av[0]; end
            default: begin e.add = (av * 2) + {7'd0, c}; e.acr = av[7]; end
        endcase
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; b_inv = 1'b0; carry = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_add, o_zr, o_acr, o_avr, o_hc, o_busy, o_done} !== {8'h00, 1'b1, 5'b00000}) begin
            errors++;
            $display("FAIL reset_state got add=%h zr=%b acr=%b avr=%b hc=%b busy=%b done=%b required add=00 zr=1 others 0",
                     o_add, o_zr, o_acr, o_avr, o_hc, o_busy, o_done);
        end else $display("ok reset_state");
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        issue(3'd0, 8'h50, 8'h50, 1'b0, 1'b0);
        push("sum_50_50", 8'hA0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        issue(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0);
        push("sum_ff_01", 8'h00, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (o_done !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back_done got %b required 1", o_done);
        end
        @(negedge clk);
        checks++;
        if (o_done !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse got %b required 0", o_done);
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_shift_logic();
        @(negedge clk);
        issue(3'd4, 8'h81, 8'h00, 1'b0, 1'b1);
        push("srs_81_c1", 8'hC0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        issue(3'd5, 8'h81, 8'h00, 1'b0, 1'b0);
        push("sls_81_c0", 8'h02, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        issue(3'd1, 8'hF0, 8'h3C, 1'b1, 1'b0);
        push("and_inv", 8'hC0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_drain("shift_logic");
    endtask

    task automatic test_decimal();
        // o_add holds 0xC0 from the preceding AND.
        @(negedge clk);
        issue(3'd6, 8'h58, 8'h46, 1'b0, 1'b1);
`ifdef CPU6502_ALU_DECIMAL_EN
        push("dsum_58_46", 8'h05, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start = 1'b0;
            checks++;
            if ({o_busy, o_done, o_add} !== {1'b1, 1'b0, 8'hC0}) begin
                errors++;
                $display("FAIL dsum_busy_cycle%0d got busy=%b done=%b add=%h required busy=1 done=0 add=c0",
                         k, o_busy, o_done, o_add);
            end
        end
`else
        push("dsum_as_sum", 8'h9F, 1'b0, 1'b1, 1'b0);
`endif
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({o_busy, o_done} !== 2'b01) begin
            errors++;
            $display("FAIL dsum_completion got busy=%b done=%b required busy=0 done=1", o_busy, o_done);
        end
        wait_drain("dsum");
`ifdef CPU6502_ALU_DECIMAL_EN
        run_op("dsub_40_13", 3'd7, 8'h40, 8'h13, 1'b0, 1'b1, 8'h27, 1'b1, 1'b0, 1'b0);
        run_op("dsub_00_01", 3'd7, 8'h00, 8'h01, 1'b0, 1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
`else
        run_op("dsub_40_13_bin", 3'd7, 8'h40, 8'h13, 1'b0, 1'b1, 8'h2D, 1'b1, 1'b0, 1'b0);
        run_op("dsub_00_01_bin", 3'd7, 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
`endif
    endtask

    task automatic test_busy_ignore();
`ifdef CPU6502_ALU_DECIMAL_EN
        @(negedge clk);
        issue(3'd6, 8'h11, 8'h22, 1'b0, 1'b0);
        push("dsum_11_22", 8'h33, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        issue(3'd0, 8'h01, 8'h01, 1'b0, 1'b0);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_during_ignore got %b required 1", o_busy);
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain("busy_ignore");
        repeat (3) @(negedge clk);
        checks++;
        if (o_add !== 8'h33) begin
            errors++;
            $display("FAIL ignored_start_hold got %h required 33", o_add);
        end
`else
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_tied_low got %b required 0", o_busy);
        end
`endif
    endtask

    task automatic test_reset_abort();
`ifdef CPU6502_ALU_DECIMAL_EN
        @(negedge clk);
        issue(3'd6, 8'h58, 8'h46, 1'b0, 1'b1);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_done, o_busy, o_add, o_zr} !== {1'b0, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL abort_dec got done=%b busy=%b add=%h zr=%b required done=0 busy=0 add=00 zr=1",
                     o_done, o_busy, o_add, o_zr);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
`endif
        // Reset wins over a start presented on the same edge.
        run_op("pre_abort_sum", 3'd0, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        issue(3'd0, 8'h50, 8'h50, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({o_done, o_add} !== {1'b0, 8'h00}) begin
            errors++;
            $display("FAIL reset_priority got done=%b add=%h required done=0 add=00", o_done, o_add);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [W-1:0] av, bv;
        logic inv, c;
        for (int i = 0; i < 12; i++) begin
            o = 3'($urandom_range(0, 5));
            av = 8'($urandom); bv = 8'($urandom);
            inv = 1'($urandom); c = 1'($urandom);
            @(negedge clk);
            issue(o, av, bv, inv, c);
            sb.push_back(model(o, av, bv, inv, c));
        end
        @(negedge clk);
        start = 1'b0;
        wait_drain("random");
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_shift_logic();
        test_decimal();
        test_busy_ignore();
        test_reset_abort();
        test_random();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
